mips_state_sequencer: RTL and testbench

//  Multi-cycle state sequencer for the MIPS CPU. Owns the 3-bit state register that drives the control signal decoder.

---
 rtl/mips_cpu_pkg.sv | 65 ++++++
 rtl/mips_wait_timer.sv | 29 ++
 rtl/mips_state_sequencer.sv | 105 ++++++++++
 tb/tb_mips_state_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU types: sequencer states, opcodes, function codes.
// Also holds the instruction-class helpers used by the sequencer.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    FETCH_INSTR   = 3'd0,
    DECODE        = 3'd1,
    EXECUTE       = 3'd2,
    MEMORY_ACCESS = 3'd3,
    WRITE_BACK    = 3'd4,
    HALTED        = 3'd5
  } state_t;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_REGIMM  = 6'h01,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_BLEZ    = 6'h06,
    OP_BGTZ    = 6'h07,
    OP_ADDIU   = 6'h09,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_JR    = 6'h08,
    FN_MTHI  = 6'h11,
    FN_MTLO  = 6'h13,
    FN_MULT  = 6'h18,
    FN_MULTU = 6'h19,
    FN_DIV   = 6'h1A,
    FN_DIVU  = 6'h1B,
    FN_ADDU  = 6'h21
  } func_code_t;

  function automatic logic is_load_store(
    input logic [5:0] op
  );
    return op[5];
  endfunction

  // True for instructions that finish in EXECUTE (no result write)
  function automatic logic is_jump_branch(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    logic r;
    r = 1'b0;
    if (op == OP_SPECIAL) begin
      case (fn)
        FN_JR, FN_MTHI, FN_MTLO,
        FN_MULT, FN_MULTU,
        FN_DIV, FN_DIVU: r = 1'b1;
        default:         r = 1'b0;
      endcase
    end else begin
      r = (op >= OP_REGIMM) && (op <= OP_BGTZ);
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_wait_timer.sv
// Counts consecutive stalled memory cycles in one state.
// Flags a timeout once WAIT_MAX stalls have elapsed.
module mips_wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic clear,
  output logic timeout
);

  localparam int W = $clog2(WAIT_MAX + 1);

  logic [W-1:0] cnt_q;

  assign timeout = waiting && (cnt_q == W'(WAIT_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (waiting) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/mips_state_sequencer.sv
// Multi-cycle state sequencer for the MIPS CPU.
// Drives the control decoder state and halt/error status.
module mips_state_sequencer
  import mips_cpu_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CYCLE_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func_code,
  input  logic               waitrequest,
  input  logic               alu_busy,
  input  logic               pc_zero,
  output logic [2:0]         state,
  output logic               advance,
  output logic               active,
  output logic               bus_error,
  output logic [CYCLE_W-1:0] cycle_count
);

  state_t               state_q;
  state_t               state_d;
  logic                 active_q;
  logic                 bus_error_q;
  logic [CYCLE_W-1:0]   cnt_q;
  logic                 ls;
  logic                 waiting;
  logic                 changing;
  logic                 timeout;

  assign ls = is_load_store(opcode);

  // A halt request in fetch pre-empts the stall count
  assign waiting = waitrequest &&
    (((state_q == FETCH_INSTR) && !pc_zero) ||
     ((state_q == MEMORY_ACCESS) && ls));

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_INSTR: begin
        if (pc_zero || timeout)
          state_d = HALTED;
        else if (!waitrequest)
          state_d = DECODE;
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        if (!alu_busy)
          state_d = is_jump_branch(opcode, func_code)
                    ? FETCH_INSTR : MEMORY_ACCESS;
      end
      MEMORY_ACCESS: begin
        if (!ls)
          state_d = FETCH_INSTR;
        else if (timeout)
          state_d = HALTED;
        else if (!waitrequest)
          state_d = opcode[3] ? FETCH_INSTR : WRITE_BACK;
      end
      WRITE_BACK: state_d = FETCH_INSTR;
      HALTED:     state_d = HALTED;
      default:    state_d = HALTED;
    endcase
  end

  assign changing = (state_d != state_q);
  // Entering HALTED must not commit any architectural write
  assign advance  = changing && (state_d != HALTED);

  mips_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .waiting(waiting),
    .clear  (changing),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH_INSTR;
      active_q    <= 1'b1;
      bus_error_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == HALTED)
        active_q <= 1'b0;
      if (timeout)
        bus_error_q <= 1'b1;
      if (active_q && (cnt_q != {CYCLE_W{1'b1}}))
        cnt_q <= cnt_q + CYCLE_W'(1);
    end
  end

  assign state       = state_q;
  assign active      = active_q;
  assign bus_error   = bus_error_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_mips_state_sequencer.sv
// Directed self-checking bench for mips_state_sequencer.
// Small WAIT_MAX and CYCLE_W expose timeout and saturation.
module tb_mips_state_sequencer;

  localparam int WAIT_MAX = 4;
  localparam int CYCLE_W  = 6;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [5:0]         opcode = '0;
  logic [5:0]         func_code = '0;
  logic               waitrequest = 1'b0;
  logic               alu_busy = 1'b0;
  logic               pc_zero = 1'b0;
  logic [2:0]         state;
  logic               advance;
  logic               active;
  logic               bus_error;
  logic [CYCLE_W-1:0] cycle_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_state_sequencer #(
    .WAIT_MAX(WAIT_MAX),
    .CYCLE_W (CYCLE_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .func_code  (func_code),
    .waitrequest(waitrequest),
    .alu_busy   (alu_busy),
    .pc_zero    (pc_zero),
    .state      (state),
    .advance    (advance),
    .active     (active),
    .bus_error  (bus_error),
    .cycle_count(cycle_count)
  );

  task automatic chk_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic do_reset;
    reset       = 1'b0;
    opcode      = '0;
    func_code   = '0;
    waitrequest = 1'b0;
    alu_busy    = 1'b0;
    pc_zero     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    #1;
    chk_eq({tag, " state"}, 32'(state), 32'd0);
    chk_eq({tag, " active"}, 32'(active), 32'd1);
    chk_eq({tag, " bus_err"}, 32'(bus_error), 32'd0);
    chk_eq({tag, " cyc"}, 32'(cycle_count), 32'd0);
  endtask

  // st: one state per nibble, step 0 in the low nibble
  task automatic run_vec(
    input string        tag,
    input logic [5:0]   op,
    input logic [5:0]   fn,
    input int           n,
    input logic [63:0]  st,
    input logic [15:0]  adv,
    input logic [15:0]  wr,
    input logic [15:0]  busy
  );
    do_reset();
    opcode    = op;
    func_code = fn;
    for (int i = 0; i < n; i++) begin
      waitrequest = wr[i];
      alu_busy    = busy[i];
      #1;
      chk_eq($sformatf("%s st%0d", tag, i),
             32'(state), 32'(st[i*4 +: 4]));
      chk_eq($sformatf("%s adv%0d", tag, i),
             32'(advance), 32'(adv[i]));
      @(negedge clk);
    end
    waitrequest = 1'b0;
    alu_busy    = 1'b0;
  endtask

  initial begin
    do_reset();
    check_reset("rst");

    run_vec("addu", 6'h00, 6'h21, 5,
            64'h03210, 16'b11111, 16'h0, 16'h0);
    #1;
    chk_eq("addu cyc", 32'(cycle_count), 32'd5);

    run_vec("lw", 6'h23, 6'h00, 9,
            64'h043333210, 16'b111000111,
            16'b000111000, 16'h0);

    run_vec("mult", 6'h00, 6'h18, 9,
            64'h022222210, 16'b110000011,
            16'h0, 16'b001111111);

    run_vec("sw", 6'h2B, 6'h00, 6,
            64'h033210, 16'b110111,
            16'b001000, 16'h0);

    run_vec("j", 6'h02, 6'h00, 4,
            64'h0210, 16'b1111, 16'h0, 16'h0);

    run_vec("addiu", 6'h09, 6'h00, 5,
            64'h03210, 16'b11111,
            16'b01000, 16'h0);

    // halt beats a simultaneous fetch stall
    do_reset();
    pc_zero     = 1'b1;
    waitrequest = 1'b1;
    #1;
    chk_eq("halt adv", 32'(advance), 32'd0);
    @(negedge clk);
    #1;
    chk_eq("halt state", 32'(state), 32'd5);
    chk_eq("halt active", 32'(active), 32'd0);
    chk_eq("halt cyc", 32'(cycle_count), 32'd1);
    chk_eq("halt berr", 32'(bus_error), 32'd0);
    pc_zero     = 1'b0;
    waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_eq("halt hold", 32'(state), 32'd5);
    chk_eq("halt frozen", 32'(cycle_count), 32'd1);

    // fetch stall timeout
    do_reset();
    waitrequest = 1'b1;
    for (int i = 0; i <= WAIT_MAX; i++) begin
      #1;
      chk_eq($sformatf("to st%0d", i), 32'(state), 32'd0);
      chk_eq($sformatf("to berr%0d", i),
             32'(bus_error), 32'd0);
      chk_eq($sformatf("to adv%0d", i),
             32'(advance), 32'd0);
      @(negedge clk);
    end
    #1;
    chk_eq("to state", 32'(state), 32'd5);
    chk_eq("to berr", 32'(bus_error), 32'd1);
    chk_eq("to active", 32'(active), 32'd0);
    do_reset();
    check_reset("rst2");

    // async reset while stalled in EXECUTE
    do_reset();
    func_code = 6'h18;
    alu_busy  = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk_eq("ar pre st", 32'(state), 32'd2);
    chk_eq("ar pre cyc", 32'(cycle_count), 32'd4);
    #1;
    reset = 1'b0;
    #1;
    chk_eq("ar state", 32'(state), 32'd0);
    chk_eq("ar cyc", 32'(cycle_count), 32'd0);
    chk_eq("ar active", 32'(active), 32'd1);

    // cycle counter saturation
    do_reset();
    func_code = 6'h21;
    repeat (70) @(negedge clk);
    #1;
    chk_eq("sat cyc", 32'(cycle_count), 32'h3F);
    chk_eq("sat active", 32'(active), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
